move_input_ctrl: RTL and testbench
==================================

MOVE_INPUT_CTRL -- requirements
Module: move_input_ctrl

Interface
REQ-001 Parameter DB_CYCLES, default 500000, debounce hold time in clk cycles (range 2..2^20-1).
REQ-002 Parameter TICK_DIV, default 2097152, move-tick period in clk cycles (range 2..2^24-1).
REQ-003 Clocking: one clock, clk; reset is asynchronous and active-high, named reset.
REQ-004 Port: clk  input  1  board clock; all state on rising edge.
REQ-005 Port: reset  input  1  asynchronous, active-high; clears all state.
REQ-006 Port: enable  input  1  game-active qualifier; gates ticks and strobes.
REQ-007 Port: btnU, btnD, btnL, btnR  input  1 each  raw asynchronous push-buttons, active-high.
REQ-008 Port: held_u, held_d, held_l, held_r  output  1 each  debounced button levels.
REQ-009 Port: press_u, press_d, press_l, press_r  output  1 each  one-cycle pulse on debounced rising edge.
REQ-010 Port: mv_up, mv_down, mv_left, mv_right  output  1 each  one-cycle move strobes at tick rate.
REQ-011 Port: tick  output  1  one-cycle pulse per move period.

Function
REQ-012 Each button SHALL pass through a 2-flop synchronizer before any other logic.
REQ-013 Debounce per button: 20-bit counter; sync==held -> counter<=0; sync!=held and counter<DB_CYCLES-1 -> counter+1; sync!=held and counter==DB_CYCLES-1 -> held<=sync, counter<=0.
REQ-014 Raw-to-held latency SHALL be exactly 2+DB_CYCLES cycles for a clean edge; any glitch shorter than DB_CYCLES sync cycles SHALL not change held.
REQ-015 Debounce FSM per button has states IDLE (held=0, counter=0), ARMING (held=0, counter>0), PRESSED (held=1, counter=0), RELEASING (held=1, counter>0); transitions follow REQ-013 only.
REQ-016 press_x SHALL be registered and assert for exactly one cycle, the cycle after held_x goes 0->1, only if enable=1.
REQ-017 Tick counter: 24-bit; when enable=1, counts 0..TICK_DIV-1 and wraps to 0; tick=1 (registered) in the cycle after counter==TICK_DIV-1.
REQ-018 enable=0 SHALL hold the tick counter at 0 and force tick, mv_*, press_* to 0; held_* keeps tracking buttons.
REQ-019 enable 0->1 SHALL restart the period: first tick exactly TICK_DIV cycles after enable rises.
REQ-020 mv_x SHALL be asserted in the same cycle as tick when held_x=1 and the opposing held level is 0 (up vs down, left vs right).
REQ-021 Both opposing buttons held: neither strobe of that axis asserts; the other axis is unaffected.
REQ-022 Vertical and horizontal strobes MAY assert together (diagonal move).
REQ-023 A button becoming held in the same cycle as a tick SHALL not produce a strobe for that tick (strobe uses held value from the previous cycle).

Reset
REQ-024 While reset=1: synchronizers, debounce counters, tick counter = 0; held_*, press_*, mv_*, tick = 0.
REQ-025 Reset asserted mid-debounce or mid-period SHALL discard progress; after release behaviour is identical to power-up.
REQ-026 Buttons already pressed at reset release SHALL be seen held after 2+DB_CYCLES cycles and SHALL generate press_x.

Verification (DB_CYCLES=4, TICK_DIV=8)
REQ-027 enable=1, btnU 0->1 at cycle 0 held -> held_u=1 at cycle 6, press_u=1 at cycle 7 only, mv_up=1 on every tick thereafter.
REQ-028 btnL pulses high 3 cycles then low -> held_l stays 0, no press_l, no mv_left.
REQ-029 btnU and btnD both held, btnR held, enable=1 -> every tick: mv_right=1, mv_up=mv_down=0.
REQ-030 enable rises at cycle 10 with btnD held since reset -> ticks at cycles 18, 26, 34; mv_down coincides; enable drops at 30 -> no tick at 34.
REQ-031 reset asserted at cycle 3 of a 6-cycle btnR debounce, released next cycle, btnR kept high -> held_r rises 6 cycles after release, not earlier.

Source files
------------

// File: rtl/move_input_ctrl.sv
// Push-button front end for a grid game: per-button synchronise + debounce,
// rising-edge press pulses, and tick-rate move strobes with opposing-axis cancel.

module move_input_debounce #(
    parameter int DB_CYCLES = 500000
) (
    input  logic clk,
    input  logic reset,
    input  logic btn,
    output logic held
);
    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        ARMING    = 2'd1,
        PRESSED   = 2'd2,
        RELEASING = 2'd3
    } db_state_t;

    localparam logic [19:0] LAST = 20'(DB_CYCLES - 1);

    logic [1:0]  sync;
    logic        level;
    logic [19:0] count;
    db_state_t   state;

    assign level = sync[1];

    // The counter only runs while the synchronised level disagrees with held;
    // any agreement (a glitch ending) drops the progress back to zero.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sync  <= 2'b00;
            count <= '0;
            held  <= 1'b0;
            state <= IDLE;
        end else begin
            sync <= {sync[0], btn};
            case (state)
                IDLE: begin
                    if (level) begin
                        count <= 20'd1;
                        state <= ARMING;
                    end
                end
                ARMING: begin
                    if (!level) begin
                        count <= '0;
                        state <= IDLE;
                    end else if (count == LAST) begin
                        count <= '0;
                        held  <= 1'b1;
                        state <= PRESSED;
                    end else begin
                        count <= count + 20'd1;
                    end
                end
                PRESSED: begin
                    if (!level) begin
                        count <= 20'd1;
                        state <= RELEASING;
                    end
                end
                RELEASING: begin
                    if (level) begin
                        count <= '0;
                        state <= PRESSED;
                    end else if (count == LAST) begin
                        count <= '0;
                        held  <= 1'b0;
                        state <= IDLE;
                    end else begin
                        count <= count + 20'd1;
                    end
                end
                default: begin
                    count <= '0;
                    held  <= 1'b0;
                    state <= IDLE;
                end
            endcase
        end
    end
endmodule

module move_input_ctrl #(
    parameter int DB_CYCLES = 500000,
    parameter int TICK_DIV  = 2097152
) (
    input  logic clk,
    input  logic reset,
    input  logic enable,
    input  logic btnU,
    input  logic btnD,
    input  logic btnL,
    input  logic btnR,
    output logic held_u,
    output logic held_d,
    output logic held_l,
    output logic held_r,
    output logic press_u,
    output logic press_d,
    output logic press_l,
    output logic press_r,
    output logic mv_up,
    output logic mv_down,
    output logic mv_left,
    output logic mv_right,
    output logic tick
);
    localparam logic [23:0] TICK_LAST = 24'(TICK_DIV - 1);

    // Bit order everywhere below: 0 = up, 1 = down, 2 = left, 3 = right.
    logic [3:0]  btn;
    logic [3:0]  held;
    logic [3:0]  held_prev;
    logic [3:0]  press_q;
    logic [3:0]  mv_q;
    logic [3:0]  dir_ok;
    logic [23:0] tick_cnt;
    logic        tick_q;
    logic        wrap;

    assign btn = {btnR, btnL, btnD, btnU};

    for (genvar i = 0; i < 4; i++) begin : g_db
        move_input_debounce #(.DB_CYCLES(DB_CYCLES)) u_db (
            .clk  (clk),
            .reset(reset),
            .btn  (btn[i]),
            .held (held[i])
        );
    end

    assign wrap   = (tick_cnt == TICK_LAST);
    assign dir_ok = {held[3] & ~held[2], held[2] & ~held[3],
                     held[1] & ~held[0], held[0] & ~held[1]};

    // Strobes are registered alongside tick, so they see held from the cycle
    // before the tick; a button settling on the tick cycle waits a period.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            held_prev <= '0;
            press_q   <= '0;
            mv_q      <= '0;
            tick_cnt  <= '0;
            tick_q    <= 1'b0;
        end else begin
            held_prev <= held;
            press_q   <= held & ~held_prev & {4{enable}};
            if (enable) begin
                tick_cnt <= wrap ? '0 : tick_cnt + 24'd1;
                tick_q   <= wrap;
                mv_q     <= {4{wrap}} & dir_ok;
            end else begin
                tick_cnt <= '0;
                tick_q   <= 1'b0;
                mv_q     <= '0;
            end
        end
    end

    // Game-inactive blanks the pulses immediately, including the cycle enable falls.
    assign tick     = tick_q & enable;
    assign mv_up    = mv_q[0] & enable;
    assign mv_down  = mv_q[1] & enable;
    assign mv_left  = mv_q[2] & enable;
    assign mv_right = mv_q[3] & enable;
    assign press_u  = press_q[0] & enable;
    assign press_d  = press_q[1] & enable;
    assign press_l  = press_q[2] & enable;
    assign press_r  = press_q[3] & enable;

    assign held_u = held[0];
    assign held_d = held[1];
    assign held_l = held[2];
    assign held_r = held[3];
endmodule

// File: tb/tb_move_input_ctrl.sv
// Self-checking bench for move_input_ctrl with a cycle-history reference model
// (debounce as "last DB synchronised samples all disagree", ticks as enabled-run length).

module tb_move_input_ctrl;
    localparam int DB = 4;
    localparam int TD = 8;

    logic clk = 1'b0;
    logic reset = 1'b1;
    logic enable = 1'b0;
    logic btnU = 1'b0, btnD = 1'b0, btnL = 1'b0, btnR = 1'b0;
    logic held_u, held_d, held_l, held_r;
    logic press_u, press_d, press_l, press_r;
    logic mv_up, mv_down, mv_left, mv_right, tick;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    move_input_ctrl #(.DB_CYCLES(DB), .TICK_DIV(TD)) dut (
        .clk(clk), .reset(reset), .enable(enable),
        .btnU(btnU), .btnD(btnD), .btnL(btnL), .btnR(btnR),
        .held_u(held_u), .held_d(held_d), .held_l(held_l), .held_r(held_r),
        .press_u(press_u), .press_d(press_d), .press_l(press_l), .press_r(press_r),
        .mv_up(mv_up), .mv_down(mv_down), .mv_left(mv_left), .mv_right(mv_right),
        .tick(tick)
    );

    // Reference model state; bit 0 = up, 1 = down, 2 = left, 3 = right.
    logic [3:0] m_s1, m_s2, m_held, m_held_p, m_press_r, m_mv_r;
    logic       m_tick_r;
    int         m_run;
    logic [3:0] m_hist[$];
    logic [7:0] exp_q[$];
    logic [7:0] obs_q[$];

    task automatic model_clear();
        m_s1 = '0; m_s2 = '0; m_held = '0; m_held_p = '0;
        m_press_r = '0; m_mv_r = '0; m_tick_r = 1'b0; m_run = 0;
        m_hist.delete();
    endtask

    task automatic model_edge(input logic [3:0] b, input logic e);
        logic [3:0] nh;
        int run_t;
        logic nt;
        logic flip;
        run_t = e ? m_run + 1 : 0;
        nt = e && (run_t > 0) && (run_t % TD == 0);
        m_mv_r[0] = nt && m_held[0] && !m_held[1];
        m_mv_r[1] = nt && m_held[1] && !m_held[0];
        m_mv_r[2] = nt && m_held[2] && !m_held[3];
        m_mv_r[3] = nt && m_held[3] && !m_held[2];
        m_press_r = m_held & ~m_held_p & {4{e}};
        m_tick_r = nt;
        m_hist.push_back(m_s2);
        if (m_hist.size() > DB) void'(m_hist.pop_front());
        nh = m_held;
        if (m_hist.size() == DB) begin
            for (int k = 0; k < 4; k++) begin
                flip = 1'b1;
                for (int j = 0; j < DB; j++)
                    if (m_hist[j][k] == m_held[k]) flip = 1'b0;
                if (flip) nh[k] = ~m_held[k];
            end
        end
        m_held_p = m_held;
        m_held = nh;
        m_s2 = m_s1;
        m_s1 = b;
        m_run = run_t;
    endtask

    function automatic logic [16:0] model_out();
        return {m_held, m_press_r & {4{enable}}, m_mv_r & {4{enable}}, m_tick_r & enable};
    endfunction

    function automatic logic [16:0] dut_out();
        return {held_r, held_l, held_d, held_u, press_r, press_l, press_d, press_u,
                mv_right, mv_left, mv_down, mv_up, tick};
    endfunction

    task automatic step(input logic [3:0] b, input logic e);
        btnU = b[0]; btnD = b[1]; btnL = b[2]; btnR = b[3];
        enable = e;
        @(posedge clk);
        model_edge(b, e);
        #1;
    endtask

    task automatic reset_on();
        reset = 1'b1;
        model_clear();
        #1;
    endtask

    task automatic reset_off(input int edges);
        repeat (edges) @(posedge clk);
        #1;
        reset = 1'b0;
    endtask

    task automatic test_reset();
        logic [16:0] got;
        enable = 1'b1;
        btnU = 1'b1; btnR = 1'b1;
        reset_on();
        got = dut_out();
        if (got !== 17'h0) begin
            errors++;
            $display("FAIL reset_outputs: got %h expected %h", got, 17'h0);
        end
        checks++;
        reset_off(3);
        got = dut_out();
        if (got !== 17'h0) begin
            errors++;
            $display("FAIL reset_release: got %h expected %h", got, 17'h0);
        end
        checks++;
        // Buttons already down at release: held at cycle 6, press at cycle 7.
        for (int i = 0; i < 10; i++) begin
            step(4'b1001, 1'b1);
            got = dut_out();
            if (got !== model_out()) begin
                errors++;
                $display("FAIL reset_held_model cycle %0d: got %h expected %h", i + 1, got, model_out());
            end
            checks++;
            if ((i + 1 == 7) && ({press_r, press_u} !== 2'b11)) begin
                errors++;
                $display("FAIL reset_held_press cycle 7: got %b expected 11", {press_r, press_u});
            end
            if (i + 1 == 7) checks++;
        end
    endtask

    task automatic test_press_up();
        logic [16:0] got;
        int first_held;
        int mv_n;
        int tick_n;
        reset_on();
        reset_off(2);
        first_held = -1; mv_n = 0; tick_n = 0;
        obs_q.delete();
        for (int i = 0; i < 30; i++) begin
            step(4'b0001, 1'b1);
            got = dut_out();
            if (got !== model_out()) begin
                errors++;
                $display("FAIL press_up_model cycle %0d: got %h expected %h", i + 1, got, model_out());
            end
            checks++;
            if (held_u && first_held < 0) first_held = i + 1;
            if (press_u) obs_q.push_back(8'(i + 1));
            if (mv_up) mv_n++;
            if (tick) tick_n++;
        end
        if (first_held != 6) begin
            errors++;
            $display("FAIL press_up_latency: got %0d expected 6", first_held);
        end
        checks++;
        if (obs_q.size() != 1 || obs_q[0] != 8'd7) begin
            errors++;
            $display("FAIL press_up_pulse: got %0d pulses first %0d expected 1 pulse at 7",
                     obs_q.size(), (obs_q.size() > 0) ? obs_q[0] : 8'd0);
        end
        checks++;
        if (mv_n != 3 || tick_n != 3) begin
            errors++;
            $display("FAIL press_up_moves: got %0d mv %0d ticks expected 3 and 3", mv_n, tick_n);
        end
        checks++;
    endtask

    task automatic test_glitch();
        logic [16:0] got;
        int bad;
        reset_on();
        reset_off(2);
        bad = 0;
        for (int i = 0; i < 30; i++) begin
            step((i < 3) ? 4'b0100 : 4'b0000, 1'b1);
            got = dut_out();
            if (got !== model_out()) begin
                errors++;
                $display("FAIL glitch_model cycle %0d: got %h expected %h", i + 1, got, model_out());
            end
            checks++;
            if (held_l || press_l || mv_left) bad++;
        end
        if (bad != 0) begin
            errors++;
            $display("FAIL glitch_left: got %0d active cycles expected 0", bad);
        end
        checks++;
    endtask

    task automatic test_opposing();
        logic [16:0] got;
        int right_n;
        int vert_n;
        reset_on();
        reset_off(2);
        right_n = 0; vert_n = 0;
        for (int i = 0; i < 40; i++) begin
            step(4'b1011, 1'b1);
            got = dut_out();
            if (got !== model_out()) begin
                errors++;
                $display("FAIL opposing_model cycle %0d: got %h expected %h", i + 1, got, model_out());
            end
            checks++;
            if (mv_right) right_n++;
            if (mv_up || mv_down) vert_n++;
        end
        if (right_n != 5 || vert_n != 0) begin
            errors++;
            $display("FAIL opposing_axis: got right %0d vertical %0d expected 5 and 0", right_n, vert_n);
        end
        checks++;
    endtask

    task automatic test_enable_window();
        logic [16:0] got;
        int mvd_bad;
        btnD = 1'b1;
        reset_on();
        reset_off(2);
        exp_q.delete();
        obs_q.delete();
        exp_q.push_back(8'd18);
        exp_q.push_back(8'd26);
        mvd_bad = 0;
        for (int i = 0; i < 45; i++) begin
            step(4'b0010, (i >= 10 && i < 30));
            got = dut_out();
            if (got !== model_out()) begin
                errors++;
                $display("FAIL enable_model cycle %0d: got %h expected %h", i + 1, got, model_out());
            end
            checks++;
            if (tick) obs_q.push_back(8'(i + 1));
            if (mv_down !== tick) mvd_bad++;
        end
        if (obs_q.size() != exp_q.size()) begin
            errors++;
            $display("FAIL enable_tick_count: got %0d expected %0d", obs_q.size(), exp_q.size());
        end else begin
            foreach (exp_q[k]) begin
                if (obs_q[k] != exp_q[k]) begin
                    errors++;
                    $display("FAIL enable_tick_cycle: got %0d expected %0d", obs_q[k], exp_q[k]);
                end
            end
        end
        checks++;
        if (mvd_bad != 0) begin
            errors++;
            $display("FAIL enable_mv_down: got %0d mismatching cycles expected 0", mvd_bad);
        end
        checks++;
    endtask

    task automatic test_reset_mid();
        logic [16:0] got;
        int first_held;
        reset_on();
        reset_off(2);
        for (int i = 0; i < 3; i++) step(4'b1000, 1'b1);
        reset_on();
        if (held_r !== 1'b0) begin
            errors++;
            $display("FAIL reset_mid_clear: got %b expected 0", held_r);
        end
        checks++;
        reset_off(1);
        first_held = -1;
        for (int i = 0; i < 12; i++) begin
            step(4'b1000, 1'b1);
            got = dut_out();
            if (got !== model_out()) begin
                errors++;
                $display("FAIL reset_mid_model cycle %0d: got %h expected %h", i + 1, got, model_out());
            end
            checks++;
            if (held_r && first_held < 0) first_held = i + 1;
        end
        if (first_held != 6) begin
            errors++;
            $display("FAIL reset_mid_latency: got %0d expected 6", first_held);
        end
        checks++;
    endtask

    task automatic test_random();
        logic [16:0] got;
        logic [3:0] b;
        logic e;
        int rem[4];
        int erem;
        b = '0; e = 1'b1; erem = 20;
        for (int k = 0; k < 4; k++) rem[k] = $urandom_range(1, 10);
        reset_on();
        reset_off(2);
        for (int i = 0; i < 1500; i++) begin
            for (int k = 0; k < 4; k++) begin
                rem[k]--;
                if (rem[k] <= 0) begin
                    b[k] = ~b[k];
                    rem[k] = $urandom_range(1, 12);
                end
            end
            erem--;
            if (erem <= 0) begin
                e = ~e;
                erem = $urandom_range(3, 40);
            end
            if ($urandom_range(0, 299) == 0) begin
                reset_on();
                got = dut_out();
                if (got !== 17'h0) begin
                    errors++;
                    $display("FAIL random_reset cycle %0d: got %h expected %h", i, got, 17'h0);
                end
                checks++;
                reset_off($urandom_range(1, 3));
            end
            step(b, e);
            got = dut_out();
            if (got !== model_out()) begin
                errors++;
                $display("FAIL random_model cycle %0d: got %h expected %h", i, got, model_out());
            end
            checks++;
        end
    endtask

    initial begin
        model_clear();
        repeat (2) @(posedge clk);
        #1;
        test_reset();
        test_press_up();
        test_glitch();
        test_opposing();
        test_enable_window();
        test_reset_mid();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
